// File: rtl/modulo_job_sequencer.sv
// -----------------------------------------------------------------------------
// modulo_job_sequencer
//
// Feeds operand pairs to a 16-bit modulo unit and collects its results.
// Operand pairs arrive on a valid/ready port and are buffered in a small FIFO.
// One job at a time is issued to the modulo unit with a one-cycle start pulse.
// The unit's result is captured and presented downstream with valid/ready
// backpressure. A zero divisor is trapped without starting the unit. A job
// whose result never arrives is aborted after TIMEOUT wait cycles.
//
// Ports
//   clk             rising-edge clock
//   rst_i           asynchronous active-high reset (also resets the modulo unit)
//   in_valid_i      operand pair valid
//   in_ready_o      FIFO has a free slot
//   in_zahl1_i      dividend
//   in_zahl2_i      divisor
//   fill_o          FIFO occupancy
//   mod_start_o     one-cycle start pulse to the modulo unit
//   mod_zahl1_o     dividend to the modulo unit (held from pop to next pop)
//   mod_zahl2_o     divisor to the modulo unit (held from pop to next pop)
//   mod_valid_i     modulo unit result valid
//   mod_ergebnis_i  modulo unit result
//   res_valid_o     result available downstream
//   res_ready_i     downstream accepts the result
//   res_ergebnis_o  remainder (0 on error)
//   res_err_o       00 = ok, 01 = divisor zero, 10 = timeout
//   busy_o          sequencer is not idle
// -----------------------------------------------------------------------------
module modulo_job_sequencer #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 131071
) (
   input  logic                     clk,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [WIDTH-1:0]         in_zahl1_i,
   input  logic [WIDTH-1:0]         in_zahl2_i,
   output logic [$clog2(DEPTH):0]   fill_o,
   output logic                     mod_start_o,
   output logic [WIDTH-1:0]         mod_zahl1_o,
   output logic [WIDTH-1:0]         mod_zahl2_o,
   input  logic                     mod_valid_i,
   input  logic [WIDTH-1:0]         mod_ergebnis_i,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [WIDTH-1:0]         res_ergebnis_o,
   output logic [1:0]               res_err_o,
   output logic                     busy_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam int CW = $clog2(TIMEOUT);

   localparam logic [FW-1:0] FULL_LEVEL = FW'(DEPTH);
   localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_DIV0    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

   state_t            state;
   logic [WIDTH-1:0]  mem_zahl1 [DEPTH];
   logic [WIDTH-1:0]  mem_zahl2 [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [FW-1:0]     count;
   logic [CW-1:0]     wait_cnt;
   logic              push;
   logic              pop;

   assign in_ready_o = (count < FULL_LEVEL);
   assign fill_o     = count;
   assign busy_o     = (state != IDLE);
   assign push       = in_valid_i && in_ready_o;
   // The FSM is the only consumer: it takes the head whenever it is idle.
   assign pop        = (state == IDLE) && (count != '0);

   // FIFO storage holds data only; validity is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_zahl1[wr_ptr] <= in_zahl1_i;
         mem_zahl2[wr_ptr] <= in_zahl2_i;
      end
   end

   // FIFO pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + FW'(1);
            2'b01:   count <= count - FW'(1);
            default: count <= count;
         endcase
      end
   end

   // Job state machine with registered outputs.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state          <= IDLE;
         mod_start_o    <= 1'b0;
         mod_zahl1_o    <= '0;
         mod_zahl2_o    <= '0;
         res_valid_o    <= 1'b0;
         res_ergebnis_o <= '0;
         res_err_o      <= ERR_OK;
         wait_cnt       <= '0;
      end else begin
         mod_start_o <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  mod_zahl1_o <= mem_zahl1[rd_ptr];
                  mod_zahl2_o <= mem_zahl2[rd_ptr];
                  if (mem_zahl2[rd_ptr] == '0) begin
                     // Divide by zero never reaches the unit.
                     res_ergebnis_o <= '0;
                     res_err_o      <= ERR_DIV0;
                     res_valid_o    <= 1'b1;
                     state          <= OUT;
                  end else begin
                     mod_start_o <= 1'b1;
                     state       <= START;
                  end
               end
            end
            START: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               // wait_cnt == 0 marks the first WAIT cycle, where a valid still
               // asserted from the previous job must not be taken. A valid in
               // the final WAIT cycle beats the timeout.
               if (mod_valid_i && (wait_cnt != '0)) begin
                  res_ergebnis_o <= mod_ergebnis_i;
                  res_err_o      <= ERR_OK;
                  res_valid_o    <= 1'b1;
                  state          <= OUT;
               end else if (wait_cnt == WAIT_LAST) begin
                  res_ergebnis_o <= '0;
                  res_err_o      <= ERR_TIMEOUT;
                  res_valid_o    <= 1'b1;
                  state          <= OUT;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            OUT: begin
               if (res_ready_i) begin
                  res_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_modulo_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_modulo_job_sequencer
//
// Directed bench for modulo_job_sequencer (TIMEOUT = 32). A small stub models
// the modulo unit: it answers stub_lat cycles after a start pulse with the
// remainder, and can be silenced (stub_on = 0). force_valid lets a scenario
// inject a stale valid. All expected values below are hand-computed.
// -----------------------------------------------------------------------------
module tb_modulo_job_sequencer;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [15:0] in_zahl1_i = '0;
   logic [15:0] in_zahl2_i = '0;
   logic [2:0]  fill_o;
   logic        mod_start_o;
   logic [15:0] mod_zahl1_o;
   logic [15:0] mod_zahl2_o;
   logic        mod_valid_i;
   logic [15:0] mod_ergebnis_i;
   logic        res_valid_o;
   logic        res_ready_i = 1'b1;
   logic [15:0] res_ergebnis_o;
   logic [1:0]  res_err_o;
   logic        busy_o;

   int n_cmp = 0;
   int n_err = 0;

   // modulo unit stub
   int          stub_lat = 5;
   logic        stub_on = 1'b1;
   logic [7:0]  stub_cnt = '0;
   logic [15:0] stub_a = '0;
   logic [15:0] stub_b = '0;
   logic        stub_valid = 1'b0;
   logic [15:0] stub_erg = '0;
   logic        force_valid = 1'b0;
   logic [15:0] force_erg = '0;

   assign mod_valid_i    = stub_valid | force_valid;
   assign mod_ergebnis_i = force_valid ? force_erg : stub_erg;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mod_start_o) begin
         stub_cnt <= 8'(stub_lat - 1);
         stub_a   <= mod_zahl1_o;
         stub_b   <= mod_zahl2_o;
      end else if (stub_cnt != 8'd0) begin
         stub_cnt <= stub_cnt - 8'd1;
      end
      stub_valid <= stub_on && !mod_start_o && (stub_cnt == 8'd1);
      stub_erg   <= (stub_b != 16'd0) ? (stub_a % stub_b) : 16'd0;
   end

   modulo_job_sequencer #(
      .WIDTH   (16),
      .DEPTH   (4),
      .TIMEOUT (32)
   ) dut (
      .clk            (clk),
      .rst_i          (rst_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .in_zahl1_i     (in_zahl1_i),
      .in_zahl2_i     (in_zahl2_i),
      .fill_o         (fill_o),
      .mod_start_o    (mod_start_o),
      .mod_zahl1_o    (mod_zahl1_o),
      .mod_zahl2_o    (mod_zahl2_o),
      .mod_valid_i    (mod_valid_i),
      .mod_ergebnis_i (mod_ergebnis_i),
      .res_valid_o    (res_valid_o),
      .res_ready_i    (res_ready_i),
      .res_ergebnis_o (res_ergebnis_o),
      .res_err_o      (res_err_o),
      .busy_o         (busy_o)
   );

   // Offer one pair; returns at the negedge after the accepting posedge.
   task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
      in_valid_i = 1'b1;
      in_zahl1_i = a;
      in_zahl2_i = b;
      for (int k = 0; k < 200 && !in_ready_o; k++) @(negedge clk);
      if (!in_ready_o) begin
         n_cmp++; n_err++;
         $display("FAIL push_accept: in_ready_o stuck at 0 for pair %0d,%0d", a, b);
      end
      @(negedge clk);
      in_valid_i = 1'b0;
   endtask

   // Observe maxc negedges (index 0 = now): start pulses and first result.
   task automatic watch(input int maxc, output int starts, output int t_start,
                        output int t_res, output logic [15:0] erg, output logic [1:0] err);
      starts = 0; t_start = -1; t_res = -1; erg = '0; err = '0;
      for (int k = 0; k < maxc; k++) begin
         if (mod_start_o) begin
            starts++;
            if (t_start < 0) t_start = k;
         end
         if (res_valid_o && t_res < 0) begin
            t_res = k; erg = res_ergebnis_o; err = res_err_o;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (fill_o !== 3'd0) begin n_err++; $display("FAIL reset_fill: got %0d expected 0", fill_o); end
      n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
      n_cmp++; if (mod_start_o !== 1'b0) begin n_err++; $display("FAIL reset_start: got %0b expected 0", mod_start_o); end
      n_cmp++; if (res_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid_o); end
      n_cmp++; if (res_err_o !== 2'b00) begin n_err++; $display("FAIL reset_err: got %0b expected 00", res_err_o); end
      n_cmp++; if (res_ergebnis_o !== 16'd0) begin n_err++; $display("FAIL reset_erg: got %0d expected 0", res_ergebnis_o); end
      rst_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int starts, ts, tr; logic [15:0] erg; logic [1:0] err;
      stub_lat = 5; stub_on = 1'b1; res_ready_i = 1'b1;
      push_pair(16'd100, 16'd7);
      n_cmp++; if (fill_o !== 3'd1) begin n_err++; $display("FAIL basic_fill_after_push: got %0d expected 1", fill_o); end
      watch(30, starts, ts, tr, erg, err);
      n_cmp++; if (starts !== 1) begin n_err++; $display("FAIL basic_start_count: got %0d expected 1", starts); end
      n_cmp++; if (ts !== 1) begin n_err++; $display("FAIL basic_start_latency: got %0d expected 1", ts); end
      n_cmp++; if (tr !== 7) begin n_err++; $display("FAIL basic_res_latency: got %0d expected 7", tr); end
      n_cmp++; if (erg !== 16'd2) begin n_err++; $display("FAIL basic_result: got %0d expected 2", erg); end
      n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL basic_err: got %0b expected 00", err); end
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %0b expected 0", busy_o); end
   endtask

   task automatic test_div_zero();
      int starts, ts, tr; logic [15:0] erg; logic [1:0] err;
      res_ready_i = 1'b1;
      push_pair(16'd1234, 16'd0);
      watch(10, starts, ts, tr, erg, err);
      n_cmp++; if (starts !== 0) begin n_err++; $display("FAIL div0_no_start: got %0d starts expected 0", starts); end
      n_cmp++; if (tr !== 1) begin n_err++; $display("FAIL div0_res_latency: got %0d expected 1", tr); end
      n_cmp++; if (erg !== 16'd0) begin n_err++; $display("FAIL div0_result: got %0d expected 0", erg); end
      n_cmp++; if (err !== 2'b01) begin n_err++; $display("FAIL div0_err: got %0b expected 01", err); end
      n_cmp++; if (mod_zahl1_o !== 16'd1234) begin n_err++; $display("FAIL div0_zahl1_held: got %0d expected 1234", mod_zahl1_o); end
   endtask

   task automatic test_stale_valid();
      int starts, ts, tr; logic [15:0] erg; logic [1:0] err;
      stub_lat = 4; stub_on = 1'b1; res_ready_i = 1'b1;
      push_pair(16'd50, 16'd8);
      @(negedge clk);
      n_cmp++; if (mod_start_o !== 1'b1) begin n_err++; $display("FAIL stale_start: got %0b expected 1", mod_start_o); end
      force_erg = 16'h0BAD; force_valid = 1'b1;
      repeat (2) @(negedge clk);
      force_valid = 1'b0;
      watch(10, starts, ts, tr, erg, err);
      n_cmp++; if (tr !== 3) begin n_err++; $display("FAIL stale_res_latency: got %0d expected 3", tr); end
      n_cmp++; if (erg !== 16'd2) begin n_err++; $display("FAIL stale_result: got %0d expected 2", erg); end
      n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL stale_err: got %0b expected 00", err); end
   endtask

   task automatic test_back_to_back();
      int starts, ts, tr, got_n; logic [15:0] erg; logic [1:0] err;
      logic [15:0] exp_r [5];
      logic [15:0] got_r [8];
      logic [1:0]  got_e [8];
      exp_r[0] = 16'd4; exp_r[1] = 16'd3; exp_r[2] = 16'd12; exp_r[3] = 16'd255; exp_r[4] = 16'd96;
      stub_lat = 3; stub_on = 1'b1; res_ready_i = 1'b0;
      push_pair(16'd100, 16'd9);
      watch(8, starts, ts, tr, erg, err);
      n_cmp++; if (erg !== 16'd1) begin n_err++; $display("FAIL bp_first_result: got %0d expected 1", erg); end
      push_pair(16'd200, 16'd7);
      push_pair(16'd300, 16'd11);
      push_pair(16'd1000, 16'd13);
      push_pair(16'd65535, 16'd256);
      n_cmp++; if (fill_o !== 3'd4) begin n_err++; $display("FAIL bp_fill_full: got %0d expected 4", fill_o); end
      n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full: got %0b expected 0", in_ready_o); end
      in_zahl1_i = 16'd4096; in_zahl2_i = 16'd100; in_valid_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++; if (res_ergebnis_o !== 16'd1 || res_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_hold_result: got %0d/%0b expected 1/1", res_ergebnis_o, res_valid_o); end
         n_cmp++; if (fill_o !== 3'd4) begin n_err++; $display("FAIL bp_fill_hold: got %0d expected 4", fill_o); end
      end
      res_ready_i = 1'b1;
      @(negedge clk);
      res_ready_i = 1'b0;
      n_cmp++; if (res_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %0b expected 0", res_valid_o); end
      @(negedge clk);
      n_cmp++; if (fill_o !== 3'd3) begin n_err++; $display("FAIL bp_fill_after_pop: got %0d expected 3", fill_o); end
      n_cmp++; if (mod_zahl1_o !== 16'd200) begin n_err++; $display("FAIL bp_pop_head: got %0d expected 200", mod_zahl1_o); end
      @(negedge clk);
      in_valid_i = 1'b0;
      n_cmp++; if (fill_o !== 3'd4) begin n_err++; $display("FAIL bp_fifth_accepted: got %0d expected 4", fill_o); end
      res_ready_i = 1'b1;
      got_n = 0;
      for (int k = 0; k < 150; k++) begin
         if (res_valid_o && got_n < 8) begin
            got_r[got_n] = res_ergebnis_o; got_e[got_n] = res_err_o; got_n++;
         end
         @(negedge clk);
      end
      n_cmp++; if (got_n !== 5) begin n_err++; $display("FAIL bp_result_count: got %0d expected 5", got_n); end
      for (int i = 0; i < 5; i++) begin
         if (i < got_n) begin
            n_cmp++; if (got_r[i] !== exp_r[i] || got_e[i] !== 2'b00) begin n_err++; $display("FAIL bp_order[%0d]: got %0d err %0b expected %0d err 00", i, got_r[i], got_e[i], exp_r[i]); end
         end
      end
   endtask

   task automatic test_timeout();
      int starts, ts, tr; logic [15:0] erg; logic [1:0] err;
      stub_on = 1'b0; res_ready_i = 1'b1;
      push_pair(16'd77, 16'd5);
      push_pair(16'd77, 16'd4);
      watch(34, starts, ts, tr, erg, err);
      n_cmp++; if (ts !== 0) begin n_err++; $display("FAIL to_start: got %0d expected 0", ts); end
      // 32 WAIT cycles follow the start cycle; the result shows one cycle later.
      n_cmp++; if (tr !== 33) begin n_err++; $display("FAIL to_latency: got %0d expected 33", tr); end
      n_cmp++; if (err !== 2'b10) begin n_err++; $display("FAIL to_err: got %0b expected 10", err); end
      n_cmp++; if (erg !== 16'd0) begin n_err++; $display("FAIL to_result: got %0d expected 0", erg); end
      stub_on = 1'b1; stub_lat = 5;
      watch(15, starts, ts, tr, erg, err);
      n_cmp++; if (ts !== 1 || tr !== 7) begin n_err++; $display("FAIL to_next_job_timing: got start %0d res %0d expected 1 7", ts, tr); end
      n_cmp++; if (erg !== 16'd1 || err !== 2'b00) begin n_err++; $display("FAIL to_next_job: got %0d err %0b expected 1 err 00", erg, err); end
      // Valid in the last WAIT cycle wins over the timeout.
      stub_lat = 32;
      push_pair(16'd77, 16'd6);
      watch(40, starts, ts, tr, erg, err);
      n_cmp++; if (tr !== 34) begin n_err++; $display("FAIL to_edge_latency: got %0d expected 34", tr); end
      n_cmp++; if (erg !== 16'd5 || err !== 2'b00) begin n_err++; $display("FAIL to_edge_valid_wins: got %0d err %0b expected 5 err 00", erg, err); end
      stub_lat = 5;
   endtask

   task automatic test_reset_mid_job();
      int starts, ts, tr; logic [15:0] erg; logic [1:0] err;
      stub_on = 1'b0; res_ready_i = 1'b1;
      push_pair(16'd10, 16'd3);
      push_pair(16'd20, 16'd3);
      push_pair(16'd30, 16'd3);
      repeat (2) @(negedge clk);
      n_cmp++; if (fill_o !== 3'd2 || busy_o !== 1'b1) begin n_err++; $display("FAIL rst_pre_state: got fill %0d busy %0b expected 2 1", fill_o, busy_o); end
      n_cmp++; if (mod_zahl1_o !== 16'd10) begin n_err++; $display("FAIL rst_pre_zahl1: got %0d expected 10", mod_zahl1_o); end
      #2 rst_i = 1'b1;
      #1;
      n_cmp++; if (fill_o !== 3'd0 || in_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_async_fifo: got fill %0d ready %0b expected 0 1", fill_o, in_ready_o); end
      n_cmp++; if (busy_o !== 1'b0 || mod_zahl1_o !== 16'd0 || mod_zahl2_o !== 16'd0) begin n_err++; $display("FAIL rst_async_fsm: got busy %0b z1 %0d z2 %0d expected 0 0 0", busy_o, mod_zahl1_o, mod_zahl2_o); end
      @(negedge clk);
      rst_i = 1'b0;
      stub_on = 1'b1;
      watch(30, starts, ts, tr, erg, err);
      n_cmp++; if (starts !== 0 || tr !== -1) begin n_err++; $display("FAIL rst_no_result: got starts %0d res at %0d expected 0 -1", starts, tr); end
      n_cmp++; if (fill_o !== 3'd0) begin n_err++; $display("FAIL rst_fill_after: got %0d expected 0", fill_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_stale_valid();
      test_back_to_back();
      test_timeout();
      test_reset_mid_job();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/modulo_job_sequencer.md
Name: modulo_job_sequencer

Overview:
- Upstream feeder and result collector for the 16-bit modulo unit.
- Buffers operand pairs (Zahl1, Zahl2) from a valid/ready source in a small FIFO and issues one job at a time to the modulo unit via start pulse.
- Captures the unit's result on its valid and presents it downstream with valid/ready backpressure.
- Traps division by zero and hung jobs (timeout).

Parameters:
WIDTH, 16, operand/result width; matches modulo unit.
DEPTH, 4, FIFO entries; power of two, >=2.
TIMEOUT, 131071, max WAIT cycles before abort; >=8.

Ports:
clk  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high; also drives the modulo unit's reset
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  FIFO not full
in_zahl1_i  in  WIDTH  dividend
in_zahl2_i  in  WIDTH  divisor
fill_o  out  clog2(DEPTH)+1  FIFO occupancy
mod_start_o  out  1  one-cycle start pulse to modulo unit
mod_zahl1_o  out  WIDTH  dividend to modulo unit
mod_zahl2_o  out  WIDTH  divisor to modulo unit
mod_valid_i  in  1  modulo unit result valid
mod_ergebnis_i  in  WIDTH  modulo unit result
res_valid_o  out  1  result available
res_ready_i  in  1  downstream accepts result
res_ergebnis_o  out  WIDTH  remainder
res_err_o  out  2  01 = divisor zero, 10 = timeout, 00 = ok
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, immediate):
  - FIFO emptied, fill_o=0, in_ready_o=1.
  - State IDLE; mod_start_o=0.
  - mod_zahl1_o, mod_zahl2_o, res_ergebnis_o = 0; res_valid_o=0, res_err_o=00, busy_o=0.
  - Timeout counter cleared.
- Reset mid-job discards the job and all queued entries; no result is emitted.
- FIFO:
  - Push when in_valid_i & in_ready_o.
  - in_ready_o = (fill < DEPTH), derived from registered count.
  - Push and pop in the same cycle keep fill unchanged.
  - Pointers wrap modulo DEPTH.
  - No push when full; no pop when empty.
- State machine IDLE, START, WAIT, OUT:
  - IDLE:
    - If FIFO non-empty: pop head into operand registers (mod_zahl1_o/mod_zahl2_o).
    - If popped zahl2==0: go to OUT with res_ergebnis_o=0 and res_err_o=01; no start is issued.
    - Otherwise go to START.
  - START:
    - mod_start_o=1 for exactly this cycle; clear timeout counter; go to WAIT.
  - WAIT:
    - mod_valid_i is ignored in the first WAIT cycle (masks stale valid from the previous job).
    - From the second WAIT cycle, mod_valid_i=1 captures mod_ergebnis_i into res_ergebnis_o, sets res_err_o=00, and goes to OUT.
    - Counter increments each WAIT cycle. When it reaches TIMEOUT-1 without valid: res_ergebnis_o=0, res_err_o=10, go to OUT.
    - Valid arriving in the same cycle as the timeout wins: result captured, err 00.
  - OUT:
    - res_valid_o=1; res_ergebnis_o and res_err_o held stable while res_ready_i=0.
    - On res_ready_i=1: go to IDLE, res_valid_o=0 next cycle.
- mod_zahl1_o/mod_zahl2_o are held constant from the pop until the next pop.
- Latency:
  - Push at edge t; pop in IDLE during cycle t+1; mod_start_o high in cycle t+2.
  - res_valid_o rises 1 cycle after the accepted mod_valid_i.
  - Divisor-zero case: res_valid_o rises 1 cycle after the pop.
- Throughput: one job in flight; the FIFO accepts pushes in every state.
- No combinational path from any input to any output except in_ready_o's dependence on fill (registered).

Test Plan:
- Push (100,7), res_ready_i=1, stub returns 2 five cycles after start → exactly one mod_start_o pulse; res_valid_o=1, res_ergebnis_o=2, res_err_o=00; busy_o back to 0.
- Push (1234,0) → no mod_start_o; res_valid_o one cycle after pop with res_ergebnis_o=0, res_err_o=01.
- Hold res_ready_i=0, push 5 pairs back-to-back → in_ready_o drops after the 4th push is accepted and fill_o=4 in the next cycle, falling to 3 once IDLE pops the head. The 5th pair is not accepted until a slot frees; the first result stays on res_ergebnis_o unchanged until ready, then the results emerge in push order.
- TIMEOUT=32, stub never asserts mod_valid_i → res_err_o=10, res_ergebnis_o=0 exactly 32 WAIT cycles after start; the next queued job then issues normally.
- Stub holds mod_valid_i=1 from the previous job into the first WAIT cycle → it is ignored; the correct later result is captured.
- Assert rst_i during WAIT with 2 entries queued → all outputs reset immediately; after release, no result is emitted and fill_o=0.
